// File: rtl/merge_sched_pkg.sv
// Shared types and helpers for the 5-way merge select scheduler.
package merge_sched_pkg;

  localparam int unsigned DEF_N_IN  = 5;
  localparam int unsigned DEF_SEL_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  // Wrap increment over 0..n-1; n need not be a power of two.
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
  endfunction

endpackage

// File: rtl/merge5_sel_scheduler_rr_pick_n.sv
// Rotating-priority picker: first set request at or after ptr, wrapping N-1 -> 0.
module rr_pick_n #(
  parameter int unsigned N = 5,
  parameter int unsigned W = 3
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  int unsigned  cand;
  logic [N-1:0] shifted;

  // Scan N candidates starting at ptr; explicit compare handles non-power-of-two N.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = 32'd0;
    shifted = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = 32'(ptr_i) + i;
      if (cand >= N) cand = cand - N;
      shifted = req_i >> cand;
      if (!found_o && shifted[0]) begin
        found_o = 1'b1;
        idx_o   = W'(cand);
      end
    end
  end

endmodule

// File: rtl/merge5_sel_scheduler.sv
// Round-robin scheduler issuing one select token at a time to the 5-way merge.
module merge5_sel_scheduler
  import merge_sched_pkg::*;
#(
  parameter int unsigned N_IN    = DEF_N_IN,
  parameter int unsigned SEL_W   = DEF_SEL_W,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IN-1:0]  req_i,
  output logic [N_IN-1:0]  gnt_o,
  output logic             sel_valid,
  input  logic             sel_ready,
  output logic [SEL_W-1:0] sel_data,
  input  logic             out_done,
  output logic             busy,
  output logic             timeout_err,
  output logic             spurious_err
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_e           state_q;
  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] idx_q;
  logic [TW-1:0]    timer_q;
  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;

  rr_pick_n #(
    .N (N_IN),
    .W (SEL_W)
  ) u_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // Grant FSM; all outputs are registered and follow the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      idx_q        <= '0;
      timer_q      <= '0;
      gnt_o        <= '0;
      sel_valid    <= 1'b0;
      sel_data     <= '0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
      spurious_err <= 1'b0;
    end else begin
      if (out_done && (state_q != ST_WAIT)) spurious_err <= 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          if (pick_found) begin
            idx_q     <= pick_idx;
            sel_data  <= pick_idx;
            sel_valid <= 1'b1;
            busy      <= 1'b1;
            state_q   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (sel_ready) begin
            sel_valid <= 1'b0;
            timer_q   <= '0;
            gnt_o     <= N_IN'(1) << idx_q;
            state_q   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Done wins over a coincident expiry.
          if (out_done || (timer_q == TW'(TIMEOUT - 1))) begin
            if (!out_done) timeout_err <= 1'b1;
            gnt_o   <= '0;
            busy    <= 1'b0;
            ptr_q   <= SEL_W'(next_idx(32'(idx_q), N_IN));
            state_q <= ST_IDLE;
          end else if (timer_q != '1) begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_merge5_sel_scheduler.sv
// Randomized and directed bench for merge5_sel_scheduler against a transaction-level model.
module tb_merge5_sel_scheduler;

  localparam int unsigned N   = 5;
  localparam int unsigned SW  = 3;
  localparam int unsigned TMO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_i = '0;
  logic [N-1:0]  gnt_o;
  logic          sel_valid;
  logic          sel_ready = 1'b0;
  logic [SW-1:0] sel_data;
  logic          out_done = 1'b0;
  logic          busy;
  logic          timeout_err;
  logic          spurious_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  merge5_sel_scheduler #(
    .N_IN    (N),
    .SEL_W   (SW),
    .TIMEOUT (TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req_i),
    .gnt_o        (gnt_o),
    .sel_valid    (sel_valid),
    .sel_ready    (sel_ready),
    .sel_data     (sel_data),
    .out_done     (out_done),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .spurious_err (spurious_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: who is being offered, who holds the grant, how long.
  bit m_offer = 0, m_granted = 0, m_tmo = 0, m_spur = 0;
  int m_idx = 0, m_ptr = 0, m_age = 0;
  int c;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_offer = 0; m_granted = 0; m_tmo = 0; m_spur = 0;
      m_idx = 0; m_ptr = 0; m_age = 0;
    end else begin
      if (out_done && !m_granted) m_spur = 1;
      if (m_granted) begin
        m_age++;
        if (out_done || m_age == TMO) begin
          if (!out_done) m_tmo = 1;
          m_granted = 0;
          m_ptr = (m_idx + 1) % N;
        end
      end else if (m_offer) begin
        if (sel_ready) begin
          m_offer = 0; m_granted = 1; m_age = 0;
        end
      end else if (req_i != '0) begin
        for (int k = 0; k < N; k++) begin
          c = (m_ptr + k) % N;
          if (req_i[c]) begin
            m_idx = c; m_offer = 1;
            break;
          end
        end
      end
    end
  end

  // Per-cycle compare plus log of each new token the DUT offers.
  int       dut_seq[$];
  bit       prev_v = 0;
  logic [N-1:0] exp_gnt;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 0;
    end else begin
      exp_gnt = m_granted ? (N'(1) << m_idx) : '0;
      check("cyc_sel_valid", 32'(sel_valid), 32'(m_offer));
      check("cyc_sel_data", 32'(sel_data), 32'(m_idx));
      check("cyc_gnt", 32'(gnt_o), 32'(exp_gnt));
      check("cyc_busy", 32'(busy), 32'(m_offer | m_granted));
      check("cyc_timeout_err", 32'(timeout_err), 32'(m_tmo));
      check("cyc_spurious_err", 32'(spurious_err), 32'(m_spur));
      if (sel_valid && !prev_v) dut_seq.push_back(int'(sel_data));
      prev_v = sel_valid;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_gnt(input string name);
    int n = 0;
    while (gnt_o == '0 && n < 30) begin
      tick(1);
      n++;
    end
    check(name, 32'(gnt_o != '0), 32'd1);
  endtask

  task automatic serve(input string name, input int hold);
    wait_gnt(name);
    tick(hold);
    out_done = 1'b1;
    tick(1);
    out_done = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset values
    tick(2);
    check("rst_gnt", 32'(gnt_o), 32'd0);
    check("rst_sel_valid", 32'(sel_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_errs", 32'({timeout_err, spurious_err}), 32'd0);
    rst_n = 1'b1;
    tick(1);

    // Single request with a stalled sel channel
    req_i = 5'b00100;
    sel_ready = 1'b0;
    tick(1);
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", 32'(sel_valid), 32'd1);
      check("stall_data", 32'(sel_data), 32'd2);
      tick(1);
    end
    sel_ready = 1'b1;
    tick(1);
    check("hs_gnt", 32'(gnt_o), 32'b00100);
    check("hs_valid_low", 32'(sel_valid), 32'd0);
    req_i = '0;
    sel_ready = 1'b0;
    tick(2);
    out_done = 1'b1;
    tick(1);
    out_done = 1'b0;
    check("done_idle", 32'(busy), 32'd0);
    // Pointer now 3: with bits 0 and 3 requesting, 3 wins
    req_i = 5'b01001;
    sel_ready = 1'b1;
    wait_gnt("ptr3_wait");
    check("ptr3_gnt", 32'(gnt_o), 32'b01000);
    req_i = '0;
    tick(1);
    out_done = 1'b1;
    tick(1);
    out_done = 1'b0;

    // Reset mid-WAIT drops the grant in the same timestep
    req_i = 5'b00100;
    wait_gnt("mid_rst_wait");
    check("mid_rst_pre_gnt", 32'(gnt_o), 32'b00100);
    tick(1);
    rst_n = 1'b0;
    #1;
    check("async_gnt", 32'(gnt_o), 32'd0);
    check("async_valid", 32'(sel_valid), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    req_i = '0;
    tick(2);
    rst_n = 1'b1;

    // Full request vector: round-robin with wrap, starting from ptr 0
    dut_seq.delete();
    req_i = 5'b11111;
    sel_ready = 1'b1;
    for (int i = 0; i < 7; i++) serve("rr_wait", 1);
    req_i = '0;
    tick(3);
    check("rr_count", 32'(dut_seq.size()), 32'd7);
    if (dut_seq.size() == 7) begin
      check("rr_0", 32'(dut_seq[0]), 32'd0);
      check("rr_1", 32'(dut_seq[1]), 32'd1);
      check("rr_2", 32'(dut_seq[2]), 32'd2);
      check("rr_3", 32'(dut_seq[3]), 32'd3);
      check("rr_4", 32'(dut_seq[4]), 32'd4);
      check("rr_5", 32'(dut_seq[5]), 32'd0);
      check("rr_6", 32'(dut_seq[6]), 32'd1);
    end

    // Move ptr to 3, then sparse requests 0 and 2
    req_i = 5'b00100;
    serve("ptr_to3", 1);
    dut_seq.delete();
    req_i = 5'b00101;
    for (int i = 0; i < 3; i++) serve("sparse_wait", 1);
    req_i = '0;
    tick(3);
    check("sparse_count", 32'(dut_seq.size()), 32'd3);
    if (dut_seq.size() == 3) begin
      check("sparse_0", 32'(dut_seq[0]), 32'd0);
      check("sparse_1", 32'(dut_seq[1]), 32'd2);
      check("sparse_2", 32'(dut_seq[2]), 32'd0);
    end

    // Timeout on idx 1 after exactly TMO WAIT cycles
    req_i = 5'b00010;
    wait_gnt("tmo_wait");
    check("tmo_gnt", 32'(gnt_o), 32'b00010);
    req_i = '0;
    tick(TMO - 1);
    check("tmo_still_busy", 32'(busy), 32'd1);
    check("tmo_not_yet", 32'(timeout_err), 32'd0);
    tick(1);
    check("tmo_idle", 32'(busy), 32'd0);
    check("tmo_err", 32'(timeout_err), 32'd1);
    req_i = 5'b11111;
    wait_gnt("tmo_ptr_wait");
    check("tmo_ptr2", 32'(gnt_o), 32'b00100);
    req_i = '0;
    out_done = 1'b1;
    tick(1);
    out_done = 1'b0;

    // Done on the last WAIT cycle wins over expiry
    pulse_reset();
    req_i = 5'b00010;
    wait_gnt("edge_wait");
    req_i = '0;
    tick(TMO - 1);
    out_done = 1'b1;
    tick(1);
    out_done = 1'b0;
    check("edge_no_tmo", 32'(timeout_err), 32'd0);
    check("edge_idle", 32'(busy), 32'd0);
    check("edge_no_spur", 32'(spurious_err), 32'd0);

    // out_done while idle
    tick(2);
    out_done = 1'b1;
    tick(1);
    out_done = 1'b0;
    check("spur_err", 32'(spurious_err), 32'd1);
    check("spur_idle", 32'(busy), 32'd0);
    tick(2);
    check("spur_no_gnt", 32'(gnt_o), 32'd0);
    check("spur_no_valid", 32'(sel_valid), 32'd0);

    // Random traffic, checked every cycle against the model
    for (int ph = 0; ph < 2; ph++) begin
      pulse_reset();
      for (int i = 0; i < 1200; i++) begin
        req_i     = N'($urandom);
        if ($urandom_range(0, 3) == 0) req_i = '0;
        sel_ready = ($urandom_range(0, 2) != 0);
        out_done  = (ph == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 14) == 0);
        if ($urandom_range(0, 499) == 0) begin
          out_done = 1'b0;
          pulse_reset();
        end
        tick(1);
      end
      out_done = 1'b0;
      req_i = '0;
      tick(3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
